sma_in_pio: RTL and testbench



---
 rtl/sma_pio_pkg.sv | 15 +
 rtl/sma_in_sync.sv | 25 ++
 rtl/sma_in_pio.sv | 107 ++++++++++
 tb/tb_sma_in_pio.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sma_pio_pkg.sv
// Shared definitions for the SMA input/output PIO slaves: word address map and
// edge-type encodings.
package sma_pio_pkg;

   typedef logic [1:0] pio_addr_t;

   localparam pio_addr_t ADDR_DATA    = 2'd0;
   localparam pio_addr_t ADDR_IRQMASK = 2'd1;
   localparam pio_addr_t ADDR_EDGE    = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sma_in_sync.sv
// WIDTH x SYNC_STAGES flop synchronizer for asynchronous inputs, cleared by an
// asynchronous active-low reset.
module sma_in_sync #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
      end
   end

   assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sma_in_pio.sv
// Avalon-MM input PIO: synchronized input, edge capture and maskable level irq.
// Define SMA_IN_PIO_BIT_CLEAR_EN for write-1-to-clear edge_capture; otherwise any write clears all.
module sma_in_pio
   import sma_pio_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  pio_addr_t        address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] d1_q;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             wr_en, rd_en;
   logic             unused_wdata;

   sma_in_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (in_port),
      .sync_o  (sync_in)
   );

   assign wr_en        = chipselect & ~write_n;
   assign rd_en        = chipselect & ~read_n;
   assign unused_wdata = &{1'b0, writedata};

   always_comb begin
      case (EDGE_TYPE)
         EDGE_RISE: edge_det = sync_in & ~d1_q;
         EDGE_FALL: edge_det = ~sync_in & d1_q;
         default:   edge_det = sync_in ^ d1_q;
      endcase
   end

   always_comb begin
      clr_bits = '0;
      if (wr_en && address == ADDR_EDGE) begin
`ifdef SMA_IN_PIO_BIT_CLEAR_EN
         clr_bits = writedata[WIDTH-1:0];
`else
         clr_bits = '1;
`endif
      end
   end

   // New edges are ORed in after the clear, so a coincident set always survives.
   always_comb begin
      edge_cap_d = (edge_cap_q & ~clr_bits) | edge_det;
      irq_mask_d = irq_mask_q;
      if (wr_en && address == ADDR_IRQMASK) begin
         irq_mask_d = writedata[WIDTH-1:0];
      end
      irq_d = |(edge_cap_q & irq_mask_q);
   end

   always_comb begin
      readdata_d = '0;
      if (rd_en) begin
         case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_in;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE:    readdata_d[WIDTH-1:0] = edge_cap_q;
            default:      readdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d1_q       <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         d1_q       <= sync_in;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_sma_in_pio.sv
// Bench for sma_in_pio: rising, falling and any-edge instances on a shared bus,
// checked every cycle against a sample-history model plus directed scenarios.
module tb_sma_in_pio;

`ifdef SMA_IN_PIO_BIT_CLEAR_EN
   localparam bit BITCLR = 1'b1;
`else
   localparam bit BITCLR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect, read_n, write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] rd [3];
   logic        irq_w [3];

   int n_checks = 0;
   int n_errors = 0;

   // Model state: last three in_port samples (index 0 = newest) and per-DUT registers.
   logic [3:0]  m_samp [3];
   logic [3:0]  m_cap  [3];
   logic [3:0]  m_mask [3];
   logic [31:0] m_rd   [3];
   logic        m_irq  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sma_in_pio #(
         .WIDTH       (4),
         .EDGE_TYPE   (g),
         .SYNC_STAGES (2)
      ) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .address    (address),
         .chipselect (chipselect),
         .read_n     (read_n),
         .write_n    (write_n),
         .writedata  (writedata),
         .in_port    (in_port),
         .readdata   (rd[g]),
         .irq        (irq_w[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int g = 0; g < 3; g++) begin
         m_samp[g] = '0;
         m_cap[g]  = '0;
         m_mask[g] = '0;
         m_rd[g]   = '0;
         m_irq[g]  = 1'b0;
      end
   endtask

   // One clock: advance the model with the values present at the edge, then compare.
   task automatic tick();
      logic [3:0] sync_v, d1_v, ed, clr;
      logic       wr, rden;
      @(posedge clk);
      if (!reset_n) begin
         model_clear();
      end else begin
         sync_v = m_samp[1];
         d1_v   = m_samp[2];
         wr     = chipselect & ~write_n;
         rden   = chipselect & ~read_n;
         clr    = (wr && address == 2'd3) ? (BITCLR ? writedata[3:0] : 4'hF) : 4'h0;
         for (int g = 0; g < 3; g++) begin
            if (g == 0)      ed = sync_v & ~d1_v;
            else if (g == 1) ed = ~sync_v & d1_v;
            else             ed = sync_v ^ d1_v;
            m_irq[g] = |(m_cap[g] & m_mask[g]);
            m_rd[g]  = '0;
            if (rden) begin
               case (address)
                  2'd0:    m_rd[g] = {28'd0, sync_v};
                  2'd1:    m_rd[g] = {28'd0, m_mask[g]};
                  2'd3:    m_rd[g] = {28'd0, m_cap[g]};
                  default: m_rd[g] = '0;
               endcase
            end
            m_cap[g] = (m_cap[g] & ~clr) | ed;
            if (wr && address == 2'd1) m_mask[g] = writedata[3:0];
         end
         m_samp[2] = m_samp[1];
         m_samp[1] = m_samp[0];
         m_samp[0] = in_port;
      end
      #1;
      for (int g = 0; g < 3; g++) begin
         check($sformatf("rd%0d", g), rd[g], m_rd[g]);
         check($sformatf("irq%0d", g), {31'd0, irq_w[g]}, {31'd0, m_irq[g]});
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_idle();
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      bus_idle();
   endtask

   task automatic bus_rd(input logic [1:0] a);
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = a;
      tick();
      bus_idle();
   endtask

   initial begin
      bus_idle();
      in_port = '0;
      reset_n = 1'b0;
      model_clear();
      ticks(2);
      reset_n = 1'b1;
      ticks(3);

      // Rising capture 0 -> 0101
      in_port = 4'b0101;
      ticks(3);
      bus_rd(2'd3);
      check("cap_rise", rd[0], 32'h5);
      check("cap_fall_none", rd[1], 32'h0);
      check("cap_any", rd[2], 32'h5);
      bus_rd(2'd0);
      check("data_rd", rd[0], 32'h5);

      // Mask bit 2, then clear bit 2 via address 3
      bus_wr(2'd1, 32'h4);
      tick();
      check("irq_unmask", {31'd0, irq_w[0]}, 32'd1);
      bus_wr(2'd3, 32'h4);
      tick();
      check("irq_after_clr", {31'd0, irq_w[0]}, 32'd0);
      bus_rd(2'd3);
      check("cap_after_clr", rd[0], BITCLR ? 32'h1 : 32'h0);

      // Clear collides with a fresh rising edge on bit 0
      in_port = 4'b0000;
      ticks(4);
      bus_wr(2'd3, 32'hF);
      in_port = 4'b0001;
      ticks(2);
      bus_wr(2'd3, 32'h1);
      bus_rd(2'd3);
      check("collide_rise", rd[0] & 32'h1, 32'h1);
      check("collide_any", rd[2] & 32'h1, 32'h1);

      // Pulse 1->0->1 on bit 2 for falling / any edge types
      in_port = 4'b0000;
      ticks(4);
      bus_wr(2'd3, 32'hF);
      in_port = 4'b0100;
      ticks(4);
      bus_wr(2'd3, 32'hF);
      in_port = 4'b0000;
      ticks(4);
      bus_rd(2'd3);
      check("fall_cap", rd[1], 32'h4);
      check("any_fall", rd[2], 32'h4);
      check("rise_nofall", rd[0], 32'h0);
      bus_wr(2'd3, 32'hF);
      in_port = 4'b0100;
      ticks(4);
      bus_rd(2'd3);
      check("fall_norise", rd[1], 32'h0);
      check("any_rise", rd[2], 32'h4);
      check("rise_cap", rd[0], 32'h4);

      // Masked capture then unmask
      bus_wr(2'd1, 32'h0);
      bus_wr(2'd3, 32'hF);
      in_port = 4'b0110;
      ticks(4);
      bus_rd(2'd3);
      check("masked_cap", rd[0], 32'h2);
      check("masked_irq", {31'd0, irq_w[0]}, 32'd0);
      bus_wr(2'd1, 32'h2);
      tick();
      check("unmask_irq", {31'd0, irq_w[0]}, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
         chipselect = 1'($urandom);
         read_n     = 1'($urandom);
         write_n    = ($urandom_range(0, 3) != 0);
         address    = 2'($urandom);
         writedata  = $urandom;
         tick();
      end
      bus_idle();

      // Asynchronous reset mid-run
      in_port = '0;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         check($sformatf("rst_rd%0d", g), rd[g], 32'h0);
         check($sformatf("rst_irq%0d", g), {31'd0, irq_w[g]}, 32'd0);
      end
      model_clear();
      ticks(2);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         bus_rd(2'(a));
         check($sformatf("rst_readback%0d", a), rd[0], 32'h0);
      end
      check("rst_irq_after", {31'd0, irq_w[0]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
